// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding word fetch at a time,
// buffers up to two returned instructions with their PCs, and presents the
// head entry to the IF/ID register. A redirect from EX flushes everything
// already fetched and discards any response still in flight.
module instr_fetch #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] IF_instruction_o,
  output logic [DATA_WIDTH-1:0] IF_pc_o,
  output logic [DATA_WIDTH-1:0] IF_pc_plus4_o,
  output logic                  IF_valid_o,
  output logic                  flush_o
);

  typedef enum logic [1:0] {
    S_IDLE,  // nothing outstanding
    S_WAIT,  // one request outstanding, response will be kept
    S_DROP   // one request outstanding, response will be discarded
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q;
  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [DATA_WIDTH-1:0] ipc_q   [2];
  logic [1:0]            count_q;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] redirect_tgt;

  // A request is only made when nothing is outstanding and a slot is free,
  // so every response is guaranteed a place in the buffer even under stall.
  assign imem_req_o   = (state_q == S_IDLE) && (count_q != 2'd2);
  assign imem_addr_o  = pc_q;
  assign flush_o      = redirect_i;
  assign redirect_tgt = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

  assign push = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop  = (count_q != 2'd0) && !stall_i && !redirect_i;

  assign IF_valid_o       = (count_q != 2'd0);
  assign IF_instruction_o = IF_valid_o ? instr_q[0] : NOP_INSTR;
  assign IF_pc_o          = IF_valid_o ? ipc_q[0] : '0;
  assign IF_pc_plus4_o    = IF_valid_o ? ipc_q[0] + DATA_WIDTH'(4) : '0;

  // Request/response tracking and next-fetch PC; redirect always retargets pc_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
    end else begin
      if (redirect_i) begin
        pc_q <= redirect_tgt;
      end
      case (state_q)
        S_IDLE: begin
          if (imem_req_o && imem_gnt_i) begin
            if (redirect_i) begin
              state_q <= S_DROP;
            end else begin
              fetch_pc_q <= pc_q;
              pc_q       <= pc_q + DATA_WIDTH'(4);
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= S_IDLE;
          end else if (redirect_i) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-entry shift buffer: entry 0 is always the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      ipc_q[0]   <= '0;
      ipc_q[1]   <= '0;
    end else if (redirect_i) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          // a push only ever happens with count 0 or 1
          instr_q[count_q[0]] <= imem_rdata_i;
          ipc_q[count_q[0]]   <= fetch_pc_q;
          count_q             <= count_q + 2'd1;
        end
        2'b01: begin
          instr_q[0] <= instr_q[1];
          ipc_q[0]   <= ipc_q[1];
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr_q[0] <= imem_rdata_i;
            ipc_q[0]   <= fetch_pc_q;
          end else begin
            instr_q[0] <= instr_q[1];
            ipc_q[0]   <= ipc_q[1];
            instr_q[1] <= imem_rdata_i;
            ipc_q[1]   <= fetch_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a behavioural instruction memory plus a stream
// model (expected next PC to be delivered) checked every cycle, with directed
// scenarios for stall, redirect corners, PC wrap and reset.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] IF_instruction_o;
  logic [31:0] IF_pc_o;
  logic [31:0] IF_pc_plus4_o;
  logic        IF_valid_o;
  logic        flush_o;

  always #5 clk = ~clk;

  instr_fetch #(
    .DATA_WIDTH (32),
    .RESET_PC   (RESET_PC),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .IF_instruction_o (IF_instruction_o),
    .IF_pc_o          (IF_pc_o),
    .IF_pc_plus4_o    (IF_pc_plus4_o),
    .IF_valid_o       (IF_valid_o),
    .flush_o          (flush_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;

  // memory model controls
  int unsigned gnt_pct = 100;
  int          lat_fixed = 0;     // <0 selects random latency
  int unsigned lat_max = 3;
  bit          mem_busy = 1'b0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = '0;
  bit          stray_rv = 1'b0;

  // stream model
  logic [31:0] exp_pc = RESET_PC;
  int          n_consumed = 0;

  // last sampled values
  bit          s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_plus4;
  bit          s_granted = 1'b0;

  // One clock cycle: drive inputs after negedge, check against the stream
  // model, advance the models, return just after the following posedge.
  task automatic tick(input bit stall, input bit redir, input logic [31:0] tgt);
    bit rv;
    bit granted;
    bit consumed;
    @(negedge clk);
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    rv            = (mem_busy && mem_lat == 0) || stray_rv;
    imem_rvalid_i = rv;
    imem_rdata_i  = stray_rv ? 32'hDEAD_BEEF : (mem_addr ^ KEY);
    imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    #1;
    s_valid = IF_valid_o;
    s_pc    = IF_pc_o;
    s_plus4 = IF_plus4_sample();
    n_checks++;
    if (flush_o !== redir) begin
      n_errors++;
      $display("FAIL flush: got %b expected %b", flush_o, redir);
    end
    if (s_valid) begin
      n_checks++;
      if (IF_pc_o !== exp_pc) begin
        n_errors++;
        $display("FAIL head_pc: got %h expected %h", IF_pc_o, exp_pc);
      end
      n_checks++;
      if (IF_instruction_o !== (exp_pc ^ KEY)) begin
        n_errors++;
        $display("FAIL head_instr: got %h expected %h", IF_instruction_o, exp_pc ^ KEY);
      end
      n_checks++;
      if (IF_pc_plus4_o !== exp_pc + 32'd4) begin
        n_errors++;
        $display("FAIL head_pc_plus4: got %h expected %h", IF_pc_plus4_o, exp_pc + 32'd4);
      end
    end else begin
      n_checks++;
      if (IF_instruction_o !== NOP || IF_pc_o !== 32'd0 || IF_pc_plus4_o !== 32'd0) begin
        n_errors++;
        $display("FAIL bubble: got instr %h pc %h pc4 %h expected %h 0 0",
                 IF_instruction_o, IF_pc_o, IF_pc_plus4_o, NOP);
      end
    end
    if (imem_req_o) begin
      n_checks++;
      if (mem_busy) begin
        n_errors++;
        $display("FAIL one_outstanding: got req=1 with busy memory expected req=0");
      end
      n_checks++;
      if (imem_addr_o[1:0] !== 2'b00) begin
        n_errors++;
        $display("FAIL addr_align: got %h expected low bits 00", imem_addr_o);
      end
    end
    granted  = imem_req_o && imem_gnt_i;
    consumed = s_valid && !stall && !redir;
    if (mem_busy) begin
      if (mem_lat == 0) mem_busy = 1'b0;
      else mem_lat--;
    end
    if (granted) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, lat_max));
    end
    stray_rv = 1'b0;
    if (consumed) begin
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    s_granted = granted;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] IF_plus4_sample();
    return IF_pc_plus4_o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_busy = 1'b0;
    stray_rv = 1'b0;
    exp_pc   = RESET_PC;
  endtask

  // Wait (bounded) for the head to become valid and require it to be tgt.
  task automatic expect_first(input logic [31:0] tgt, input string name);
    for (int i = 0; i < 20 && !IF_valid_o; i++) tick(1'b0, 1'b0, '0);
    n_checks++;
    if (!IF_valid_o || IF_pc_o !== tgt) begin
      n_errors++;
      $display("FAIL %s: got valid=%b pc=%h expected valid=1 pc=%h", name, IF_valid_o, IF_pc_o, tgt);
    end
  endtask

  task automatic wait_grant(input string name);
    int i;
    i = 0;
    do begin
      tick(1'b0, 1'b0, '0);
      i++;
    end while (!s_granted && i < 20);
    n_checks++;
    if (!s_granted) begin
      n_errors++;
      $display("FAIL %s_grant_timeout: got no grant expected grant within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_fixed = 0;
    do_reset();
    n_checks++;
    if (IF_valid_o !== 1'b0 || IF_instruction_o !== NOP || IF_pc_o !== 32'd0 || IF_pc_plus4_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b i=%h pc=%h pc4=%h expected 0 %h 0 0",
               IF_valid_o, IF_instruction_o, IF_pc_o, IF_pc_plus4_o, NOP);
    end
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_req: got req=%b addr=%h expected 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    n_checks++;
    if (IF_valid_o !== 1'b1 || IF_pc_o !== RESET_PC) begin
      n_errors++;
      $display("FAIL first_fetch_latency: got v=%b pc=%h expected 1 %h", IF_valid_o, IF_pc_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int c0;
    gnt_pct = 100; lat_fixed = 0;
    c0 = n_consumed;
    repeat (20) tick(1'b0, 1'b0, '0);
    n_checks++;
    if (n_consumed - c0 < 9) begin
      n_errors++;
      $display("FAIL stream_rate: got %0d expected >= 9", n_consumed - c0);
    end
  endtask

  task automatic test_stall();
    int c0;
    gnt_pct = 100; lat_fixed = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, '0);
      if (i >= 4) begin
        n_checks++;
        if (imem_req_o !== 1'b0 || IF_valid_o !== 1'b1) begin
          n_errors++;
          $display("FAIL stall_full: got req=%b valid=%b expected 0 1", imem_req_o, IF_valid_o);
        end
      end
    end
    c0 = n_consumed;
    repeat (20) tick(1'b0, 1'b0, '0);
    n_checks++;
    if (n_consumed - c0 < 8) begin
      n_errors++;
      $display("FAIL stall_drain: got %0d expected >= 8", n_consumed - c0);
    end
  endtask

  task automatic test_redirect_wait();
    int i;
    gnt_pct = 100; lat_fixed = 2;
    wait_grant("redir_wait");
    tick(1'b0, 1'b1, 32'h0000_0103);
    lat_fixed = 0;
    n_checks++;
    if (IF_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_wait_flush: got valid=%b req=%b expected 0 0", IF_valid_o, imem_req_o);
    end
    i = 0;
    while (!imem_req_o && i < 10) begin
      tick(1'b0, 1'b0, '0);
      i++;
    end
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL redir_wait_addr: got req=%b addr=%h expected 1 00000100", imem_req_o, imem_addr_o);
    end
    expect_first(32'h0000_0100, "redir_wait_first");
  endtask

  task automatic test_redirect_corners();
    int i;
    // redirect together with a grant
    gnt_pct = 100; lat_fixed = 1;
    i = 0;
    while (!imem_req_o && i < 10) begin
      tick(1'b0, 1'b0, '0);
      i++;
    end
    tick(1'b0, 1'b1, 32'h0000_0200);
    n_checks++;
    if (imem_req_o !== 1'b0 || IF_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_gnt_drop: got req=%b valid=%b expected 0 0", imem_req_o, IF_valid_o);
    end
    expect_first(32'h0000_0200, "redir_gnt_first");
    // redirect together with the response
    lat_fixed = 0;
    wait_grant("redir_rv");
    tick(1'b0, 1'b1, 32'h0000_0301);
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0300 || IF_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_rv_idle: got req=%b addr=%h valid=%b expected 1 00000300 0",
               imem_req_o, imem_addr_o, IF_valid_o);
    end
    expect_first(32'h0000_0300, "redir_rv_first");
    // redirect while stalled with a full buffer
    repeat (6) tick(1'b1, 1'b0, '0);
    n_checks++;
    if (IF_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL redir_stall_pre: got valid=%b expected 1", IF_valid_o);
    end
    tick(1'b1, 1'b1, 32'h0000_0406);
    n_checks++;
    if (IF_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_stall_flush: got valid=%b expected 0", IF_valid_o);
    end
    expect_first(32'h0000_0404, "redir_stall_first");
  endtask

  task automatic test_wrap();
    logic [31:0] got [$];
    logic [31:0] pc4_fc;
    gnt_pct = 100; lat_fixed = 0;
    pc4_fc = 32'hFFFF_FFFF;
    tick(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      tick(1'b0, 1'b0, '0);
      if (s_valid) begin
        got.push_back(s_pc);
        if (s_pc == 32'hFFFF_FFFC) pc4_fc = s_plus4;
      end
    end
    n_checks++;
    if (got.size() != 3 || got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_seq: got %0d entries expected FFFFFFF8 FFFFFFFC 00000000", got.size());
    end
    n_checks++;
    if (pc4_fc !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_pc_plus4: got %h expected 00000000", pc4_fc);
    end
  endtask

  task automatic test_reset_mid();
    gnt_pct = 100; lat_fixed = 3;
    wait_grant("reset_mid");
    do_reset();
    gnt_pct = 0; lat_fixed = 0;
    tick(1'b0, 1'b0, '0);
    stray_rv = 1'b1;
    tick(1'b0, 1'b0, '0);
    n_checks++;
    if (IF_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL late_rvalid: got valid=%b expected 0", IF_valid_o);
    end
    gnt_pct = 100;
    expect_first(RESET_PC, "reset_mid_first");
  endtask

  task automatic test_random();
    int c0;
    bit st;
    bit rd;
    gnt_pct = 60; lat_fixed = -1; lat_max = 3;
    c0 = n_consumed;
    repeat (400) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 4);
      tick(st, rd, $urandom);
    end
    n_checks++;
    if (n_consumed - c0 < 20) begin
      n_errors++;
      $display("FAIL random_progress: got %0d expected >= 20", n_consumed - c0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_corners();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
